vga_tile_timing: RTL and testbench
==================================

// Module: vga_tile_timing
// PURPOSE
//  Generates 640x480@60 VGA timing from the 25 MHz board clock and feeds the tile renderer.
//  Outputs: registered HSync/VSync, an active-video flag, pixel and tile (cell) coordinates
//  on the 20x15 grid of 32 px tiles, and per-frame strobes.
//  Sits directly upstream of the pixel-colour logic in main, which consumes o_cell_x/o_cell_y
//  and o_active. It replaces the ad hoc h/v counters currently in main.
// PARAMETERS
//  H_SYNC_CYCLES   92   hsync pulse width, clocks
//  H_BACK_PORCH    50   clocks from end of hsync to first visible pixel
//  H_DISPLAY       640  visible pixels per line
//  H_FRONT_PORCH   18   clocks from last visible pixel to next hsync
//  V_SYNC_CYCLES   2    vsync pulse width, lines
//  V_BACK_PORCH    33   lines from end of vsync to first visible line
//  V_DISPLAY       480  visible lines
//  V_FRONT_PORCH   10   lines after the last visible line
//  TILE_SHIFT      5    log2 of tile size in pixels (32)
// PORTS
//  i_Clk           in   1   pixel clock, 25 MHz
//  i_reset_n       in   1   synchronous, active-low reset
//  o_VGA_HSync     out  1   low during sync pulse
//  o_VGA_VSync     out  1   low during sync pulse
//  o_active        out  1   high while inside the visible window
//  o_pixel_x       out  10  visible x, 0..639; 0 when !o_active
//  o_pixel_y       out  10  visible y, 0..479; 0 when !o_active
//  o_cell_x        out  5   o_pixel_x >> TILE_SHIFT, 0..19
//  o_cell_y        out  4   o_pixel_y >> TILE_SHIFT, 0..14
//  o_frame_start   out  1   1-cycle pulse at h=0, v=0
//  o_vblank_start  out  1   1-cycle pulse at h=0, v=V_SYNC+V_BP+V_DISPLAY (515); game-logic tick
// BEHAVIOUR
//  - Internal counters h_cnt 0..H_LINE-1 (800) and v_cnt 0..V_FRAME-1 (525), both 10 bit.
//  - h_cnt wraps at H_LINE-1 and v_cnt advances on that wrap. v_cnt wraps at V_FRAME-1.
//    Both wrap on the same clock at the frame end.
//  - HSync is low for h_cnt < 92. VSync is low for v_cnt < 2.
//    Active window: 142 <= h_cnt < 782 and 35 <= v_cnt < 515.
//  - pixel_x = h_cnt - 142 and pixel_y = v_cnt - 35, each computed in 10 bits.
//    Cell values are pure shifts: no multiplier, no running cell counter.
//  - All outputs are registered from the current counter values. Every output therefore lags the
//    counters by exactly 1 clock, and all outputs are mutually aligned on the same cycle.
//  - Reset (i_reset_n=0 at a rising edge): h_cnt=0, v_cnt=0, HSync=1, VSync=1, active=0,
//    pixel/cell=0, strobes=0.
//    Reset asserted mid-line or mid-frame aborts the current frame. The first edge after release
//    evaluates h=0, v=0, so o_frame_start pulses 1 clock after release.
//  - Outside the active window, pixel and cell outputs are forced to 0 and never show
//    out-of-range values, e.g. cell_x=20.
//  - No handshake. The block free-runs and the downstream stage samples it every clock.
// STRUCTURE
//  - Timing constants, H_LINE/V_FRAME and the derived window edges go in a shared include,
//    vga_params.vh. The renderer and sprite modules use the same file.
//  - One natural sub-module: wrap_counter (parameterised width/max, enable in, wrap pulse out).
//    Instantiate it twice: h, then v enabled by the h wrap.
// TESTING
//  - Reset held 3 clks, then released -> all outputs at their reset values during reset;
//    o_frame_start=1 exactly 1 clk after release, then 0.
//  - Free-run 1 line -> HSync low for exactly 92 clks, line period exactly 800 clks;
//    o_active high for exactly 640 consecutive clks.
//  - Line v=35 -> first active cycle: pixel_x=0, cell_x=0. 32 clks later: pixel_x=32, cell_x=1.
//    Last active cycle: pixel_x=639, cell_x=19. The next cycle has active=0 and cell_x=0.
//  - Full frame -> VSync low for 1600 clks (2 lines), frame period 420000 clks.
//    Visible line v=514 gives pixel_y=479, cell_y=14.
//  - o_vblank_start and o_frame_start -> each exactly one pulse per frame,
//    spaced 515*800 = 412000 clks apart.
//  - Reset pulsed at h=400, v=200 -> outputs return to reset values on the next edge;
//    timing restarts from h=0, v=0 with no truncated sync pulse after release.

Source files
------------

// File: rtl/vga_tile_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the registered output bundle.
// The renderer and sprite modules import the same package so every stage
// agrees on the window edges.
package vga_tile_timing_pkg;

    localparam int VGA_H_SYNC_CYCLES = 92;
    localparam int VGA_H_BACK_PORCH  = 50;
    localparam int VGA_H_DISPLAY     = 640;
    localparam int VGA_H_FRONT_PORCH = 18;
    localparam int VGA_V_SYNC_CYCLES = 2;
    localparam int VGA_V_BACK_PORCH  = 33;
    localparam int VGA_V_DISPLAY     = 480;
    localparam int VGA_V_FRONT_PORCH = 10;
    localparam int VGA_TILE_SHIFT    = 5;

    // Derived line/frame lengths and visible-window edges for the default mode.
    localparam int VGA_H_LINE   = VGA_H_SYNC_CYCLES + VGA_H_BACK_PORCH + VGA_H_DISPLAY + VGA_H_FRONT_PORCH;
    localparam int VGA_V_FRAME  = VGA_V_SYNC_CYCLES + VGA_V_BACK_PORCH + VGA_V_DISPLAY + VGA_V_FRONT_PORCH;
    localparam int VGA_H_ACT_LO = VGA_H_SYNC_CYCLES + VGA_H_BACK_PORCH;
    localparam int VGA_V_ACT_LO = VGA_V_SYNC_CYCLES + VGA_V_BACK_PORCH;

    // Counter and coordinate width.
    localparam int CNT_W = 10;

    // Everything the block drives, registered together so all fields align.
    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             active;
        logic [CNT_W-1:0] pixel_x;
        logic [CNT_W-1:0] pixel_y;
        logic [4:0]       cell_x;
        logic [3:0]       cell_y;
        logic             frame_start;
        logic             vblank_start;
    } vga_out_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps from MAX back to 0. wrap is combinational and high on
// the enabled cycle that performs the wrap, so it can chain a slower counter.
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             i_Clk,
    input  logic             i_reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == WIDTH'(MAX));

    // Advance when enabled; return to 0 after MAX.
    always_ff @(posedge i_Clk) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_tile_timing.sv
// VGA timing generator feeding the tile renderer: sync pulses, active flag,
// pixel and 32 px tile coordinates, and per-frame strobes.
// No handshake: the block free-runs and downstream samples every clock.
// All outputs are registered from the current counter values, so they lag the
// counters by one clock and are mutually aligned.
module vga_tile_timing
    import vga_tile_timing_pkg::*;
#(
    parameter int H_SYNC_CYCLES = VGA_H_SYNC_CYCLES,
    parameter int H_BACK_PORCH  = VGA_H_BACK_PORCH,
    parameter int H_DISPLAY     = VGA_H_DISPLAY,
    parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
    parameter int V_SYNC_CYCLES = VGA_V_SYNC_CYCLES,
    parameter int V_BACK_PORCH  = VGA_V_BACK_PORCH,
    parameter int V_DISPLAY     = VGA_V_DISPLAY,
    parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
    parameter int TILE_SHIFT    = VGA_TILE_SHIFT
) (
    input  logic             i_Clk,
    input  logic             i_reset_n,
    output logic             o_VGA_HSync,
    output logic             o_VGA_VSync,
    output logic             o_active,
    output logic [CNT_W-1:0] o_pixel_x,
    output logic [CNT_W-1:0] o_pixel_y,
    output logic [4:0]       o_cell_x,
    output logic [3:0]       o_cell_y,
    output logic             o_frame_start,
    output logic             o_vblank_start
);

    localparam int H_LINE   = H_SYNC_CYCLES + H_BACK_PORCH + H_DISPLAY + H_FRONT_PORCH;
    localparam int V_FRAME  = V_SYNC_CYCLES + V_BACK_PORCH + V_DISPLAY + V_FRONT_PORCH;
    localparam int H_ACT_LO = H_SYNC_CYCLES + H_BACK_PORCH;
    localparam int H_ACT_HI = H_ACT_LO + H_DISPLAY;
    localparam int V_ACT_LO = V_SYNC_CYCLES + V_BACK_PORCH;
    localparam int V_ACT_HI = V_ACT_LO + V_DISPLAY;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             at_origin;
    logic             h_in;
    logic             v_in;
    logic             in_win;
    logic [CNT_W-1:0] px;
    logic [CNT_W-1:0] py;
    vga_out_t         nxt;
    vga_out_t         out_q;

    wrap_counter #(
        .WIDTH (CNT_W),
        .MAX   (H_LINE - 1)
    ) u_h_cnt (
        .i_Clk     (i_Clk),
        .i_reset_n (i_reset_n),
        .en        (1'b1),
        .count     (h_cnt),
        .wrap      (h_wrap)
    );

    // Line counter steps on the h wrap, so both wrap together at frame end.
    wrap_counter #(
        .WIDTH (CNT_W),
        .MAX   (V_FRAME - 1)
    ) u_v_cnt (
        .i_Clk     (i_Clk),
        .i_reset_n (i_reset_n),
        .en        (h_wrap),
        .count     (v_cnt),
        .wrap      (v_wrap)
    );

    // High exactly when both counters sit at (0,0): after reset or after a frame wrap.
    always_ff @(posedge i_Clk) begin
        if (!i_reset_n) begin
            at_origin <= 1'b1;
        end else begin
            at_origin <= v_wrap;
        end
    end

    // Decode the current counter position into the next output bundle.
    always_comb begin
        h_in   = (h_cnt >= CNT_W'(H_ACT_LO)) && (h_cnt < CNT_W'(H_ACT_HI));
        v_in   = (v_cnt >= CNT_W'(V_ACT_LO)) && (v_cnt < CNT_W'(V_ACT_HI));
        in_win = h_in && v_in;
        px     = h_cnt - CNT_W'(H_ACT_LO);
        py     = v_cnt - CNT_W'(V_ACT_LO);

        nxt              = '0;
        nxt.hsync        = (h_cnt >= CNT_W'(H_SYNC_CYCLES));
        nxt.vsync        = (v_cnt >= CNT_W'(V_SYNC_CYCLES));
        nxt.active       = in_win;
        // Coordinates are forced to 0 outside the window so no stray cell index escapes.
        nxt.pixel_x      = in_win ? px : '0;
        nxt.pixel_y      = in_win ? py : '0;
        nxt.cell_x       = in_win ? 5'(px >> TILE_SHIFT) : '0;
        nxt.cell_y       = in_win ? 4'(py >> TILE_SHIFT) : '0;
        nxt.frame_start  = at_origin;
        nxt.vblank_start = (h_cnt == '0) && (v_cnt == CNT_W'(V_ACT_HI));
    end

    // Output register: one clock behind the counters, syncs idle high in reset.
    always_ff @(posedge i_Clk) begin
        if (!i_reset_n) begin
            out_q       <= '0;
            out_q.hsync <= 1'b1;
            out_q.vsync <= 1'b1;
        end else begin
            out_q <= nxt;
        end
    end

    assign o_VGA_HSync    = out_q.hsync;
    assign o_VGA_VSync    = out_q.vsync;
    assign o_active       = out_q.active;
    assign o_pixel_x      = out_q.pixel_x;
    assign o_pixel_y      = out_q.pixel_y;
    assign o_cell_x       = out_q.cell_x;
    assign o_cell_y       = out_q.cell_y;
    assign o_frame_start  = out_q.frame_start;
    assign o_vblank_start = out_q.vblank_start;

endmodule

// File: tb/tb_vga_tile_timing.sv
// Bench for vga_tile_timing. Instance a runs the real 640x480 mode through the
// first visible lines; instance b uses a shrunken geometry so whole frames,
// vblank strobes and random mid-frame resets fit in a short run.
module tb_vga_tile_timing;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n_a;
    logic rst_n_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT wiring ----------------
    logic       hs_a, vs_a, act_a, fs_a, vb_a;
    logic [9:0] px_a, py_a;
    logic [4:0] cx_a;
    logic [3:0] cy_a;
    logic       hs_b, vs_b, act_b, fs_b, vb_b;
    logic [9:0] px_b, py_b;
    logic [4:0] cx_b;
    logic [3:0] cy_b;

    vga_tile_timing u_dut_a (
        .i_Clk          (clk),
        .i_reset_n      (rst_n_a),
        .o_VGA_HSync    (hs_a),
        .o_VGA_VSync    (vs_a),
        .o_active       (act_a),
        .o_pixel_x      (px_a),
        .o_pixel_y      (py_a),
        .o_cell_x       (cx_a),
        .o_cell_y       (cy_a),
        .o_frame_start  (fs_a),
        .o_vblank_start (vb_a)
    );

    vga_tile_timing #(
        .H_SYNC_CYCLES (6),
        .H_BACK_PORCH  (5),
        .H_DISPLAY     (80),
        .H_FRONT_PORCH (4),
        .V_SYNC_CYCLES (2),
        .V_BACK_PORCH  (3),
        .V_DISPLAY     (40),
        .V_FRONT_PORCH (2),
        .TILE_SHIFT    (3)
    ) u_dut_b (
        .i_Clk          (clk),
        .i_reset_n      (rst_n_b),
        .o_VGA_HSync    (hs_b),
        .o_VGA_VSync    (vs_b),
        .o_active       (act_b),
        .o_pixel_x      (px_b),
        .o_pixel_y      (py_b),
        .o_cell_x       (cx_b),
        .o_cell_y       (cy_b),
        .o_frame_start  (fs_b),
        .o_vblank_start (vb_b)
    );

    // Observed bundle: {hs, vs, act, px[9:0], py[9:0], cx[4:0], cy[3:0], fs, vb}
    logic [33:0] obs_a, obs_b;
    assign obs_a = {hs_a, vs_a, act_a, px_a, py_a, cx_a, cy_a, fs_a, vb_a};
    assign obs_b = {hs_b, vs_b, act_b, px_b, py_b, cx_b, cy_b, fs_b, vb_b};

    localparam logic [33:0] RST_OUT = {2'b11, 32'd0};

    // Geometry per instance, written out from the timing rules.
    int g_hs [2] = '{92, 6};
    int g_hbp[2] = '{50, 5};
    int g_hd [2] = '{640, 80};
    int g_hfp[2] = '{18, 4};
    int g_vs [2] = '{2, 2};
    int g_vbp[2] = '{33, 3};
    int g_vd [2] = '{480, 40};
    int g_vfp[2] = '{10, 2};
    int g_ts [2] = '{5, 3};

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [33:0] got, input logic [33:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: expected outputs for linear position p clocks into a frame sequence.
    function automatic logic [33:0] model_out(input int i, input int p);
        int hl, vf, h, v, x0, y0, x, y, tile;
        logic act;
        hl   = g_hs[i] + g_hbp[i] + g_hd[i] + g_hfp[i];
        vf   = g_vs[i] + g_vbp[i] + g_vd[i] + g_vfp[i];
        h    = p % hl;
        v    = (p / hl) % vf;
        x0   = g_hs[i] + g_hbp[i];
        y0   = g_vs[i] + g_vbp[i];
        tile = 1 << g_ts[i];
        act  = (h >= x0) && (h < x0 + g_hd[i]) && (v >= y0) && (v < y0 + g_vd[i]);
        x    = act ? h - x0 : 0;
        y    = act ? v - y0 : 0;
        return {(h >= g_hs[i]), (v >= g_vs[i]), act, 10'(x), 10'(y),
                5'(x / tile), 4'(y / tile), (h == 0) && (v == 0), (h == 0) && (v == y0 + g_vd[i])};
    endfunction

    // Per-instance tracking state.
    int   pos[2];
    bit   started[2] = '{1'b0, 1'b0};
    int   cyc[2];
    logic prev_hs[2], prev_vs[2], prev_act[2];
    int   hs_run[2], vs_run[2], act_run[2];
    int   last_hfall[2], last_fs[2], last_vb[2];

    // Named spot checks on row 35 of the real mode: {active, pixel_x, cell_x}.
    task automatic spot_a(input int p, input logic [33:0] o);
        logic [15:0] sel;
        int base;
        sel  = {o[31], o[30:21], o[10:6]};
        base = 35 * 800;
        if (p == base + 142) check_val("row35_first", 34'(sel), 34'({1'b1, 10'd0, 5'd0}));
        if (p == base + 174) check_val("row35_px32", 34'(sel), 34'({1'b1, 10'd32, 5'd1}));
        if (p == base + 781) check_val("row35_last", 34'(sel), 34'({1'b1, 10'd639, 5'd19}));
        if (p == base + 782) check_val("row35_after", 34'(sel), 34'({1'b0, 10'd0, 5'd0}));
    endtask

    // Run-length and spacing measurements derived from the observed waveform.
    task automatic measure(input int i, input logic [33:0] o);
        int hl, vf;
        hl = g_hs[i] + g_hbp[i] + g_hd[i] + g_hfp[i];
        vf = g_vs[i] + g_vbp[i] + g_vd[i] + g_vfp[i];
        if (!o[33]) begin
            if (prev_hs[i]) begin
                if (last_hfall[i] >= 0)
                    check_val($sformatf("line_period%0d", i), 34'(cyc[i] - last_hfall[i]), 34'(hl));
                last_hfall[i] = cyc[i];
            end
            hs_run[i]++;
        end else if (!prev_hs[i]) begin
            check_val($sformatf("hsync_width%0d", i), 34'(hs_run[i]), 34'(g_hs[i]));
            hs_run[i] = 0;
        end
        if (!o[32]) begin
            vs_run[i]++;
        end else if (!prev_vs[i]) begin
            check_val($sformatf("vsync_width%0d", i), 34'(vs_run[i]), 34'(g_vs[i] * hl));
            vs_run[i] = 0;
        end
        if (o[31]) begin
            act_run[i]++;
        end else if (prev_act[i]) begin
            check_val($sformatf("active_run%0d", i), 34'(act_run[i]), 34'(g_hd[i]));
            act_run[i] = 0;
        end
        if (o[1]) begin
            if (last_fs[i] >= 0)
                check_val($sformatf("frame_period%0d", i), 34'(cyc[i] - last_fs[i]), 34'(hl * vf));
            last_fs[i] = cyc[i];
        end
        if (o[0]) begin
            if (last_fs[i] >= 0)
                check_val($sformatf("fs_to_vb%0d", i), 34'(cyc[i] - last_fs[i]),
                          34'((g_vs[i] + g_vbp[i] + g_vd[i]) * hl));
            if (last_vb[i] >= 0)
                check_val($sformatf("vb_period%0d", i), 34'(cyc[i] - last_vb[i]), 34'(hl * vf));
            last_vb[i] = cyc[i];
        end
        prev_hs[i]  = o[33];
        prev_vs[i]  = o[32];
        prev_act[i] = o[31];
    endtask

    task automatic mon_step(input int i, input logic rs, input logic [33:0] o);
        if (!rs) begin
            started[i]    = 1'b1;
            pos[i]        = 0;
            cyc[i]        = 0;
            prev_hs[i]    = 1'b1;
            prev_vs[i]    = 1'b1;
            prev_act[i]   = 1'b0;
            hs_run[i]     = 0;
            vs_run[i]     = 0;
            act_run[i]    = 0;
            last_hfall[i] = -1;
            last_fs[i]    = -1;
            last_vb[i]    = -1;
            check_val($sformatf("reset_out%0d", i), o, RST_OUT);
        end else if (started[i]) begin
            check_val($sformatf("outs%0d", i), o, model_out(i, pos[i]));
            if (i == 0) spot_a(pos[i], o);
            measure(i, o);
            pos[i]++;
            cyc[i]++;
        end
    endtask

    // Monitor: capture reset as seen at the edge, compare 1 time unit later.
    logic rs_a, rs_b;
    initial begin
        forever begin
            @(posedge clk);
            rs_a = rst_n_a;
            rs_b = rst_n_b;
            #1;
            mon_step(0, rs_a, obs_a);
            mon_step(1, rs_b, obs_b);
        end
    end

    // ---------------- drivers ----------------
    // Real mode: run into row 36, reset at h=400 (row 36 keeps the run short), then resume.
    task automatic drive_a();
        int target;
        int budget;
        target = 36 * 800 + 400;
        budget = 0;
        while (pos[0] != target && budget < 40000) begin
            @(negedge clk);
            budget++;
        end
        if (pos[0] != target) check_val("wait_a_timeout", 34'(pos[0]), 34'(target));
        rst_n_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        repeat (2000) @(negedge clk);
    endtask

    // Small mode: three clean frames, then random-length resets at random points.
    task automatic drive_b();
        int len;
        repeat (3 * 4465 + $urandom_range(0, 400)) @(negedge clk);
        repeat (3) begin
            len = $urandom_range(1, 4);
            rst_n_b = 1'b0;
            repeat (len) @(negedge clk);
            rst_n_b = 1'b1;
            repeat ($urandom_range(2000, 9000)) @(negedge clk);
        end
    endtask

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        fork
            drive_a();
            drive_b();
        join
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Watchdog well below the cycle ceiling.
    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
